// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR gain ramp controller.
// Imported by the stepper and the controller top.
package fir_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        MUTING,
        MUTED
    } gain_state_e;

    localparam logic [23:0] UNITY_Q12 = 24'h001000;

    // Config is only taken while the gain is parked.
    function automatic logic cfg_open(input gain_state_e s);
        return (s == IDLE) || (s == MUTED);
    endfunction

endpackage

// File: rtl/gain_stepper.sv
// One clamped gain step toward a target, shared by ramp and mute.
// A zero step or a step covering the remaining distance lands on the target.
module gain_stepper
    import fir_ctrl_pkg::*;
#(
    parameter int GAIN_WIDTH = 24,
    parameter int STEP_WIDTH = 16
) (
    input  logic [GAIN_WIDTH-1:0] i_cur,
    input  logic [GAIN_WIDTH-1:0] i_tgt,
    input  logic [STEP_WIDTH-1:0] i_step,
    output logic [GAIN_WIDTH-1:0] o_nxt,
    output logic                  o_reached
);

    logic                  w_up;
    logic [GAIN_WIDTH:0]   w_diff;
    logic [GAIN_WIDTH:0]   w_step_ext;
    logic [GAIN_WIDTH-1:0] w_step_g;

    assign w_up       = i_tgt > i_cur;
    assign w_diff     = w_up ? ({1'b0, i_tgt} - {1'b0, i_cur})
                             : ({1'b0, i_cur} - {1'b0, i_tgt});
    assign w_step_ext = {{(GAIN_WIDTH + 1 - STEP_WIDTH){1'b0}}, i_step};
    assign w_step_g   = w_step_ext[GAIN_WIDTH-1:0];

    assign o_reached = (i_step == '0) || (w_diff <= w_step_ext);

    // Stepping only happens when diff > step, so neither branch can wrap.
    assign o_nxt = o_reached ? i_tgt
                 : w_up      ? i_cur + w_step_g
                 :             i_cur - w_step_g;

endmodule

// File: rtl/fir_gain_ramp_ctrl.sv
// Click-free gain control for the FIR top: ramped targets and soft mute.
// Ramp and mute advance one step per sample strobe.
module fir_gain_ramp_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int                    GAIN_WIDTH   = 24,
    parameter int                    STEP_WIDTH   = 16,
    parameter logic [GAIN_WIDTH-1:0] UNITY_GAIN   = UNITY_Q12,
    parameter logic [STEP_WIDTH-1:0] DEFAULT_STEP = 16'd16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_samp_en,
    input  logic                  i_cfg_valid,
    output logic                  o_cfg_ready,
    input  logic [GAIN_WIDTH-1:0] i_cfg_gain,
    input  logic [STEP_WIDTH-1:0] i_cfg_step,
    input  logic                  i_mute,
    output logic [GAIN_WIDTH-1:0] o_gain,
    output logic                  o_busy,
    output logic                  o_done
);

    gain_state_e           r_state;
    logic [GAIN_WIDTH-1:0] r_gain;
    logic [GAIN_WIDTH-1:0] r_tgt;
    logic [STEP_WIDTH-1:0] r_step;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_accept;
    logic [GAIN_WIDTH-1:0] w_tgt_n;
    logic [STEP_WIDTH-1:0] w_step_n;
    logic                  w_muting;
    logic [GAIN_WIDTH-1:0] w_st_tgt;
    logic [STEP_WIDTH-1:0] w_st_step;
    logic [GAIN_WIDTH-1:0] w_st_nxt;
    logic                  w_st_reached;
    gain_state_e           w_nx_state;
    logic [GAIN_WIDTH-1:0] w_nx_gain;
    logic                  w_nx_done;

    assign w_accept = i_cfg_valid && r_ready;
    assign w_tgt_n  = w_accept ? i_cfg_gain : r_tgt;
    assign w_step_n = w_accept ? i_cfg_step : r_step;

    // Mute always heads for zero at the fixed rate.
    assign w_muting  = (r_state == MUTING);
    assign w_st_tgt  = w_muting ? '0 : r_tgt;
    assign w_st_step = w_muting ? DEFAULT_STEP : r_step;

    gain_stepper #(
        .GAIN_WIDTH (GAIN_WIDTH),
        .STEP_WIDTH (STEP_WIDTH)
    ) u_stepper (
        .i_cur     (r_gain),
        .i_tgt     (w_st_tgt),
        .i_step    (w_st_step),
        .o_nxt     (w_st_nxt),
        .o_reached (w_st_reached)
    );

    always_comb begin
        w_nx_state = r_state;
        w_nx_gain  = r_gain;
        w_nx_done  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_mute)
                    w_nx_state = MUTING;
                else if (w_accept && (i_cfg_gain != r_gain))
                    w_nx_state = RAMP;
            end
            RAMP: begin
                if (i_mute) begin
                    w_nx_state = MUTING;
                end else if (i_samp_en) begin
                    w_nx_gain = w_st_nxt;
                    if (w_st_reached) begin
                        w_nx_state = IDLE;
                        w_nx_done  = 1'b1;
                    end
                end
            end
            MUTING: begin
                if (!i_mute) begin
                    w_nx_state = (r_gain == r_tgt) ? IDLE : RAMP;
                end else if (i_samp_en) begin
                    w_nx_gain = w_st_nxt;
                    if (w_st_reached) begin
                        w_nx_state = MUTED;
                        w_nx_done  = 1'b1;
                    end
                end
            end
            MUTED: begin
                if (!i_mute)
                    w_nx_state = (r_gain == w_tgt_n) ? IDLE : RAMP;
            end
            default: w_nx_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_gain  <= UNITY_GAIN;
            r_tgt   <= UNITY_GAIN;
            r_step  <= DEFAULT_STEP;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nx_state;
            r_gain  <= w_nx_gain;
            r_tgt   <= w_tgt_n;
            r_step  <= w_step_n;
            r_ready <= cfg_open(w_nx_state);
            r_busy  <= !cfg_open(w_nx_state);
            r_done  <= w_nx_done;
        end
    end

    assign o_cfg_ready = r_ready;
    assign o_gain      = r_gain;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule
